// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fill, data access) in front of one single-ported memory.
// Holds one transaction at a time. Alternates between the requesters only when both request together.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state;
  logic [2:0] cnt;
  logic       lastD;
  logic       inWait;
  logic       complete;
  logic       grantD;

  assign inWait   = (state != IDLE);
  assign complete = inWait && (cnt == LAT);
  // D wins a conflict unless it took the previous grant.
  assign grantD   = d_req && (!i_req || !lastD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      lastD     <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 16'd0;
      mem_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD) begin
            state     <= D_WAIT;
            lastD     <= 1'b1;
            mem_addr  <= d_addr;
            mem_wr    <= d_wr;
            mem_wdata <= d_wdata;
            cnt       <= 3'd0;
          end else if (i_req) begin
            state     <= I_WAIT;
            lastD     <= 1'b0;
            mem_addr  <= i_addr;
            mem_wr    <= 1'b0;
            mem_wdata <= d_wdata;
            cnt       <= 3'd0;
          end
        end
        I_WAIT, D_WAIT: begin
          if (complete) state <= IDLE;
          else          cnt   <= cnt + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = inWait;
  assign mem_en  = inWait && (cnt == 3'd0);
  assign i_done  = complete && (state == I_WAIT);
  assign d_done  = complete && (state == D_WAIT);
  assign i_rdata = i_done ? mem_rdata : 16'd0;
  assign d_rdata = (d_done && !mem_wr) ? mem_rdata : 16'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level schedule model predicts every cycle's outputs,
// and a sparse memory model supplies read data only in the cycle it is due.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_done, d_done, mem_en, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // requester state
  bit          iPending, dPending, dWrV;
  logic [15:0] iAddrV, dAddrV, dWdataV;

  // schedule model: the single outstanding transaction
  int          cyc = 0;
  bit          haveTxn, tIsD, tWr, lastD;
  int          tIssue, tDone;
  logic [15:0] tAddr, tWdata;
  logic [15:0] expAddr, expWdata;
  bit          expWr;
  bit          randMode, stickyMode;

  logic [15:0] memArr [logic [15:0]];
  bit          ord [$];
  int          lastEn, lastID, lastDD;
  logic [15:0] lastDRdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else nPass++;
  endtask

  function automatic logic [15:0] memRead(input logic [15:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] rndAddr();
    return 16'(16'h3000 + $urandom_range(0, 15));
  endfunction

  task automatic drivePins();
    i_req = iPending; i_addr = iAddrV;
    d_req = dPending; d_wr = dWrV; d_addr = dAddrV; d_wdata = dWdataV;
  endtask

  task automatic newI();
    iPending = 1'b1; iAddrV = rndAddr();
  endtask

  task automatic newD();
    dPending = 1'b1; dWrV = 1'($urandom_range(0, 1));
    dAddrV = rndAddr(); dWdataV = 16'($urandom);
  endtask

  // Grant rule applied to the request levels seen in an idle cycle.
  task automatic decide();
    bit gD;
    if (rst) return;
    if (haveTxn && cyc <= tDone) return;
    if (!iPending && !dPending) return;
    gD      = dPending && (!iPending || !lastD);
    haveTxn = 1'b1;
    tIssue  = cyc + 1;
    tDone   = cyc + 1 + LAT;
    tIsD    = gD;
    lastD   = gD;
    tAddr   = gD ? dAddrV : iAddrV;
    tWr     = gD ? dWrV : 1'b0;
    tWdata  = dWdataV;
  endtask

  task automatic modelReset();
    haveTxn = 1'b0; lastD = 1'b0;
    expAddr = 16'd0; expWr = 1'b0; expWdata = 16'd0;
  endtask

  task automatic step();
    bit          act, eEn, eID, eDD;
    logic [15:0] rd;
    @(negedge clk);
    cyc++;
    act = haveTxn && cyc >= tIssue && cyc <= tDone;
    eEn = haveTxn && cyc == tIssue;
    eID = haveTxn && cyc == tDone && !tIsD;
    eDD = haveTxn && cyc == tDone && tIsD;
    rd  = memRead(tAddr);
    mem_rdata = ((eID || eDD) && !tWr) ? rd : 16'($urandom);
    if (eEn) begin expAddr = tAddr; expWr = tWr; expWdata = tWdata; end
    #1;
    chk("busy",      32'(busy),      32'(act));
    chk("mem_en",    32'(mem_en),    32'(eEn));
    chk("i_done",    32'(i_done),    32'(eID));
    chk("d_done",    32'(d_done),    32'(eDD));
    chk("i_rdata",   32'(i_rdata),   eID ? 32'(rd) : 32'd0);
    chk("d_rdata",   32'(d_rdata),   (eDD && !tWr) ? 32'(rd) : 32'd0);
    chk("mem_addr",  32'(mem_addr),  32'(expAddr));
    chk("mem_wr",    32'(mem_wr),    32'(expWr));
    if (expWr) chk("mem_wdata", 32'(mem_wdata), 32'(expWdata));
    chk("bothDone",  32'(i_done & d_done), 32'd0);
    if (mem_en) lastEn = cyc;
    if (i_done) begin lastID = cyc; ord.push_back(1'b0); end
    if (d_done) begin lastDD = cyc; lastDRdata = d_rdata; ord.push_back(1'b1); end
    if (eID || eDD) begin
      if (tIsD) begin
        dPending = 1'b0;
        if (tWr) memArr[tAddr] = tWdata;
        if (stickyMode) newD();
      end else begin
        iPending = 1'b0;
        if (stickyMode) newI();
      end
    end
    if (randMode) begin
      if (!iPending && $urandom_range(0, 3) == 0) newI();
      if (!dPending && $urandom_range(0, 3) == 0) newD();
    end
    drivePins();
    decide();
  endtask

  task automatic hardReset();
    rst = 1'b1;
    iPending = 1'b0; dPending = 1'b0;
    drivePins();
    modelReset();
    #1;
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_mem_en", 32'(mem_en),   32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    step(); step();
    rst = 1'b0;
  endtask

  task automatic clearMarks();
    lastEn = -1; lastID = -1; lastDD = -1; ord.delete();
  endtask

  initial begin
    int req;
    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    iAddrV = 0; dAddrV = 0; dWdataV = 0; dWrV = 0;
    randMode = 0; stickyMode = 0;
    hardReset();

    // single instruction read
    clearMarks();
    iPending = 1'b1; iAddrV = 16'h0040; drivePins(); decide(); req = cyc;
    repeat (LAT + 3) step();
    chk("i_lat_en",   lastEn - req, 1);
    chk("i_lat_done", lastID - req, 1 + LAT);

    // simultaneous requests right after reset: D first
    hardReset(); clearMarks();
    iPending = 1'b1; iAddrV = 16'h0040;
    dPending = 1'b1; dWrV = 1'b0; dAddrV = 16'h1000; dWdataV = 16'h0;
    drivePins(); decide(); req = cyc;
    repeat (2 * LAT + 5) step();
    chk("conf_d_done", lastDD - req, 1 + LAT);
    chk("conf_i_en",   lastEn - req, 3 + LAT);
    chk("conf_i_done", lastID - req, 3 + 2 * LAT);

    // data write, then read back through the memory model
    clearMarks();
    dPending = 1'b1; dWrV = 1'b1; dAddrV = 16'h2002; dWdataV = 16'hBEEF;
    drivePins(); decide(); req = cyc;
    repeat (LAT + 3) step();
    chk("wr_done",  lastDD - req, 1 + LAT);
    chk("wr_rdata", 32'(lastDRdata), 32'd0);
    clearMarks();
    dPending = 1'b1; dWrV = 1'b0; dAddrV = 16'h2002; dWdataV = 16'h1234;
    drivePins(); decide();
    repeat (LAT + 3) step();
    chk("rd_back", 32'(lastDRdata), 32'hBEEF);

    // both held continuously: alternation
    hardReset(); clearMarks();
    stickyMode = 1'b1; newI(); newD(); drivePins(); decide();
    repeat (4 * (LAT + 2) + 2) step();
    stickyMode = 1'b0;
    chk("ord_count", 32'(ord.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ord%0d", k), (k < ord.size()) ? 32'(ord[k]) : 32'd2, 32'((k % 2) == 0));
    repeat (3 * (LAT + 2)) step();

    // reset in the middle of an instruction fill
    hardReset(); clearMarks();
    iPending = 1'b1; iAddrV = 16'h0100; drivePins(); decide();
    for (int k = 0; k < 12 && !(haveTxn && cyc == tIssue + 2); k++) step();
    chk("mid_reached", 32'(haveTxn && cyc == tIssue + 2), 32'd1);
    rst = 1'b1; #1;
    chk("mid_busy",   32'(busy),      32'd0);
    chk("mid_en",     32'(mem_en),    32'd0);
    chk("mid_idone",  32'(i_done),    32'd0);
    chk("mid_rdata",  32'(i_rdata),   32'd0);
    chk("mid_addr",   32'(mem_addr),  32'd0);
    chk("mid_wdata",  32'(mem_wdata), 32'd0);
    modelReset();
    step();
    rst = 1'b0; decide(); req = cyc; clearMarks();
    repeat (LAT + 4) step();
    chk("reissue_en",   lastEn - req, 1);
    chk("reissue_done", lastID - req, 1 + LAT);

    // random traffic
    randMode = 1'b1;
    repeat (2500) step();
    randMode = 1'b0;
    repeat (4 * (LAT + 2)) step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4: cycles from memory issue cycle to data/completion; legal range 1..7.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_req  in  1  instruction-cache miss fill request; level, held until i_done.
REQ-005 i_addr  in  16  instruction fill address; stable while i_req high.
REQ-006 i_done  out  1  one-cycle pulse: instruction fill complete, i_rdata valid.
REQ-007 i_rdata  out  16  instruction fill data; 0 when i_done low.
REQ-008 d_req  in  1  data-cache miss/writeback request; level, held until d_done.
REQ-009 d_wr  in  1  1 = write, 0 = read; stable while d_req high.
REQ-010 d_addr  in  16  data address; stable while d_req high.
REQ-011 d_wdata  in  16  write data; stable while d_req high.
REQ-012 d_done  out  1  one-cycle pulse: data access complete, d_rdata valid on reads.
REQ-013 d_rdata  out  16  read data; 0 when d_done low or on write completion.
REQ-014 mem_en  out  1  one-cycle issue strobe to shared single-ported memory.
REQ-015 mem_wr  out  1  write select, valid with mem_en.
REQ-016 mem_addr  out  16  latched address, held for whole transaction.
REQ-017 mem_wdata  out  16  latched write data, held for whole transaction.
REQ-018 mem_rdata  in  16  memory read data, valid exactly MEM_LAT cycles after issue cycle.
REQ-019 busy  out  1  high in any non-IDLE state.

Function
REQ-020 States IDLE, I_WAIT, D_WAIT; exactly one transaction outstanding at a time.
REQ-021 IDLE, d_req only -> D_WAIT; i_req only -> I_WAIT; neither -> IDLE.
REQ-022 IDLE, both requests: grant D unless last_d=1, then grant I (alternation on conflict only).
REQ-023 last_d register set on every D grant, cleared on every I grant.
REQ-024 On grant edge: latch address, d_wr (0 for I), d_wdata into mem_addr/mem_wr/mem_wdata; clear 3-bit cnt to 0.
REQ-025 Issue cycle = first WAIT cycle (cnt==0): mem_en=1 for that cycle only.
REQ-026 cnt increments by 1 each WAIT cycle; saturation never reached since MEM_LAT<=7.
REQ-027 Completion cycle = cnt==MEM_LAT: assert i_done (I_WAIT) or d_done (D_WAIT) for one cycle; rdata = mem_rdata combinationally (reads only).
REQ-028 Completion edge -> IDLE; earliest next grant decided in following IDLE cycle; next issue two cycles after completion.
REQ-029 Latency: request seen in IDLE at cycle N -> mem_en at N+1 -> done at N+1+MEM_LAT.
REQ-030 Requests arriving while busy are held by requester and arbitrated in next IDLE cycle; no request lost.
REQ-031 Writes use identical timing; d_done pulses at completion, d_rdata=0.
REQ-032 Requests deasserted without done (protocol violation) ignored: latched transaction completes normally.
REQ-033 i_done and d_done never high in same cycle; mem_en never high outside issue cycle.

Reset
REQ-034 rst high: state=IDLE, cnt=0, last_d=0, mem_addr=0, mem_wdata=0, mem_wr=0; all outputs 0 immediately (asynchronous).
REQ-035 rst mid-transaction aborts it: no done pulse, late mem_rdata ignored; first grant after rst release follows REQ-021/022 with last_d=0.

Verification
REQ-036 Single I read, MEM_LAT=4: i_req at cycle 0, i_addr=0x0040 -> mem_en cycle 1, mem_addr=0x0040, mem_wr=0; i_done cycle 5, i_rdata=mem_rdata.
REQ-037 Simultaneous i_req and d_req (read 0x1000) after reset -> D granted first, d_done cycle 5; I issued cycle 7, i_done cycle 11.
REQ-038 Both held continuously for four transactions -> grant order D,I,D,I; no cycle with both dones.
REQ-039 D write d_addr=0x2002, d_wdata=0xBEEF -> mem_en with mem_wr=1, mem_wdata=0xBEEF; d_done at issue+4, d_rdata=0.
REQ-040 rst asserted at cnt==2 of I_WAIT -> busy=0 and all outputs 0 same cycle; no i_done; subsequent i_req re-issued normally.
REQ-041 MEM_LAT=1 build: request cycle 0 -> mem_en cycle 1, done cycle 2; back-to-back requests issue every 3 cycles.
